// File: rtl/regfile_dumper_if.sv
// Signal bundle between the regfile dump sequencer and its surroundings.
// The checksum member exists only when DUMP_CHECKSUM_EN is defined.
interface regfile_dumper_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              busy;
    logic              done;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;

    modport master (
        input  start, abort, first_addr, last_addr, rdata, out_ready,
        output raddr, out_valid, out_data, out_addr, busy, done, checksum
    );
    modport slave (
        output start, abort, first_addr, last_addr, rdata, out_ready,
        input  raddr, out_valid, out_data, out_addr, busy, done, checksum
    );
`else
    modport master (
        input  start, abort, first_addr, last_addr, rdata, out_ready,
        output raddr, out_valid, out_data, out_addr, busy, done
    );
    modport slave (
        output start, abort, first_addr, last_addr, rdata, out_ready,
        input  raddr, out_valid, out_data, out_addr, busy, done
    );
`endif
endinterface

// File: rtl/regfile_dumper.sv
// Walks a (possibly wrapping) regfile address range and streams each word out.
// Optional running sum of accepted words when DUMP_CHECKSUM_EN is defined.
module regfile_dumper #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input logic             clk,
    input logic             rst,
    regfile_dumper_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] raddr_reg, raddr_next;
    logic [ADDR_W-1:0] last_reg, last_next;
    logic              out_valid_reg, out_valid_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
    logic              handshake;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] checksum_reg, checksum_next;
`endif

    assign handshake = out_valid_reg && bus.out_ready;

    always_comb begin
        state_next     = state_reg;
        raddr_next     = raddr_reg;
        last_next      = last_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_addr_next  = out_addr_reg;
`ifdef DUMP_CHECKSUM_EN
        checksum_next  = checksum_reg;
`endif
        // Abort wins over a same-edge handshake, so that word is never summed.
        if (bus.abort && state_reg != IDLE) begin
            state_next     = IDLE;
            out_valid_next = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    out_valid_next = 1'b0;
                    if (bus.start) begin
                        last_next  = bus.last_addr;
                        raddr_next = bus.first_addr;
                        state_next = FETCH;
`ifdef DUMP_CHECKSUM_EN
                        checksum_next = '0;
`endif
                    end
                end
                FETCH: begin
                    out_data_next  = bus.rdata;
                    out_addr_next  = raddr_reg;
                    out_valid_next = 1'b1;
                    state_next     = SEND;
                end
                SEND: begin
                    if (handshake) begin
                        out_valid_next = 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        checksum_next  = checksum_reg + out_data_reg;
`endif
                        if (out_addr_reg == last_reg) begin
                            state_next = DONE;
                        end else begin
                            raddr_next = raddr_reg + 1'b1;
                            state_next = FETCH;
                        end
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next     = IDLE;
                    out_valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            raddr_reg     <= '0;
            last_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
`ifdef DUMP_CHECKSUM_EN
            checksum_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            raddr_reg     <= raddr_next;
            last_reg      <= last_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_addr_reg  <= out_addr_next;
`ifdef DUMP_CHECKSUM_EN
            checksum_reg  <= checksum_next;
`endif
        end
    end

    assign bus.raddr     = raddr_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_addr  = out_addr_reg;
    assign bus.busy      = (state_reg == FETCH) || (state_reg == SEND);
    assign bus.done      = (state_reg == DONE);
`ifdef DUMP_CHECKSUM_EN
    assign bus.checksum  = checksum_reg;
`endif

endmodule

// File: tb/tb_regfile_dumper.sv
// Directed bench for regfile_dumper: vector table of dump ranges plus
// backpressure, abort and mid-dump reset sequences against a regfile model.
module tb_regfile_dumper;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_dumper_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    regfile_dumper #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] regs [32];
    assign bus.rdata = regs[bus.raddr];

    int checks = 0;
    int errors = 0;
    logic [31:0] last_data;

    typedef struct {
        logic [4:0]  f;
        logic [4:0]  l;
        int          words;
        logic [31:0] sum;
        bit          hold;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge. Runs one dump and checks every word and the done pulse.
    task automatic do_dump(input logic [4:0] f, input logic [4:0] l, input int exp_words,
                           input logic [31:0] exp_sum, input bit hold,
                           input int stall_word, input int stall_cycles);
        logic [4:0]  exp_addr;
        logic [31:0] sum;
        int nwords, last_hs, stall_left;
        bit seen_valid, stalled, finished;
        exp_addr = f; sum = '0; nwords = 0; last_hs = -1; stall_left = stall_cycles;
        seen_valid = 0; stalled = 0; finished = 0;
        bus.first_addr = f; bus.last_addr = l; bus.start = 1'b1; bus.out_ready = 1'b1;
        for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (!hold) bus.start = 1'b0;
                chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
            end
            if (hold && cyc == 2) begin
                bus.first_addr = 5'd5; bus.last_addr = 5'd7;
            end
            if (bus.done) begin
                finished = 1;
                bus.start = 1'b0;
                chk("word_count", nwords, exp_words);
`ifdef DUMP_CHECKSUM_EN
                chk("checksum_at_done", bus.checksum, exp_sum);
`endif
            end else if (bus.out_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1;
                    chk("first_valid_latency", cyc, 2);
                end
                if (nwords == stall_word && stall_left > 0) begin
                    bus.out_ready = 1'b0;
                    chk("stall_addr_stable", {27'd0, bus.out_addr}, {27'd0, exp_addr});
                    chk("stall_data_stable", bus.out_data, regs[exp_addr]);
                    stall_left--;
                    stalled = 1;
                end else begin
                    bus.out_ready = 1'b1;
                    chk("word_addr", {27'd0, bus.out_addr}, {27'd0, exp_addr});
                    chk("word_data", bus.out_data, regs[exp_addr]);
                    if (last_hs >= 0 && !stalled) chk("word_gap", cyc - last_hs, 2);
                    $display("xfer addr=%0d data=%h cycle=%0d", bus.out_addr, bus.out_data, cyc);
                    last_data = bus.out_data;
                    last_hs = cyc; stalled = 0; nwords++;
                    sum = sum + regs[exp_addr];
                    exp_addr = exp_addr + 5'd1;
                end
            end
        end
        if (!finished) begin
            errors++;
            $display("FAIL dump_timeout: got no done, required done after %0d words", exp_words);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        chk("idle_not_busy", {31'd0, bus.busy}, 32'd0);
        chk("idle_no_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef DUMP_CHECKSUM_EN
        chk("checksum_held", bus.checksum, exp_sum);
`endif
        if (sum !== exp_sum && exp_words == nwords)
            $display("note: bench table sum %h differs from model sum %h", exp_sum, sum);
    endtask

    task automatic wait_addr(input logic [4:0] a, output bit found);
        found = 0;
        for (int cyc = 1; cyc <= 200 && !found; cyc++) begin
            @(negedge clk);
            if (cyc == 1) bus.start = 1'b0;
            if (bus.out_valid && bus.out_addr == a) found = 1;
        end
        if (!found) begin
            errors++;
            $display("FAIL wait_addr_timeout: got no word at addr %0d, required one", a);
        end
    endtask

    initial begin
        bit found;
        bus.start = 1'b0; bus.abort = 1'b0; bus.first_addr = '0; bus.last_addr = '0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;

        vecs[0] = '{f: 5'd0,  l: 5'd31, words: 32, sum: 32'h0000_01F0, hold: 1'b0};
        vecs[1] = '{f: 5'd30, l: 5'd1,  words: 4,  sum: 32'h4000_003E, hold: 1'b0};
        vecs[2] = '{f: 5'd21, l: 5'd21, words: 1,  sum: 32'h1000_0015, hold: 1'b1};
        vecs[3] = '{f: 5'd31, l: 5'd0,  words: 2,  sum: 32'h2000_001F, hold: 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_raddr", {27'd0, bus.raddr}, 32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_out_addr", {27'd0, bus.out_addr}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
`ifdef DUMP_CHECKSUM_EN
        chk("rst_checksum", bus.checksum, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", {31'd0, bus.busy}, 32'd0);

        for (int v = 0; v < 4; v++)
            do_dump(vecs[v].f, vecs[v].l, vecs[v].words, vecs[v].sum, vecs[v].hold, -1, 0);

        // Backpressure on word 3 for five cycles.
        do_dump(5'd0, 5'd5, 6, 32'h6000_000F, 1'b0, 3, 5);

        // Abort coincident with a handshake on addr 10.
        bus.first_addr = 5'd0; bus.last_addr = 5'd31; bus.start = 1'b1;
        wait_addr(5'd10, found);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
`ifdef DUMP_CHECKSUM_EN
        chk("abort_checksum", bus.checksum, 32'hA000_002D);
`endif
        @(negedge clk);
        chk("abort_no_done", {31'd0, bus.done}, 32'd0);
        do_dump(5'd0, 5'd0, 1, 32'h1000_0000, 1'b0, -1, 0);

        // Reset mid-dump at addr 16 while reg 17 is rewritten.
        bus.first_addr = 5'd0; bus.last_addr = 5'd31; bus.start = 1'b1;
        wait_addr(5'd16, found);
        rst = 1'b1;
        regs[17] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("mid_rst_raddr", {27'd0, bus.raddr}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        chk("mid_rst_addr", {27'd0, bus.out_addr}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
`ifdef DUMP_CHECKSUM_EN
        chk("mid_rst_checksum", bus.checksum, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_no_done", {31'd0, bus.done}, 32'd0);
        last_data = '0;
        do_dump(5'd17, 5'd17, 1, 32'hDEAD_BEEF, 1'b0, -1, 0);
        chk("reg17_new_value", last_data, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
